// File: rtl/sa_pkg.sv
// Shared constants and helpers for the output-stationary systolic multiplier.
// Defaults, FSM encoding and the out_c packing helper live here.
package sa_pkg;

  localparam int DEF_N      = 4;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_ACC_W  = 10;
  localparam int DEF_K_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sa_state_t;

  // LSB of C[i][j] inside the packed out_c bus (row-major, i*N+j).
  function automatic int c_lsb(input int i, input int j, input int n, input int acc_w);
    return (i * n + j) * acc_w;
  endfunction

endpackage

// File: rtl/systolic_matmul_if.sv
// Command, operand stream and result bundle of the systolic multiplier.
// master = producer/consumer side, slave = the multiplier.
interface systolic_matmul_if
  import sa_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int K_W    = DEF_K_W
);

  logic                    start;
  logic [K_W-1:0]          k_len;
  logic                    acc_mode;
  logic                    busy;
  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_W-1:0]     a_col;
  logic [N*DATA_W-1:0]     b_row;
  logic                    out_valid;
  logic                    out_ready;
  logic [N*N*ACC_W-1:0]    out_c;
  logic                    overflow;

  modport master (
    output start, k_len, acc_mode, in_valid, a_col, b_row, out_ready,
    input  busy, in_ready, out_valid, out_c, overflow
  );

  modport slave (
    input  start, k_len, acc_mode, in_valid, a_col, b_row, out_ready,
    output busy, in_ready, out_valid, out_c, overflow
  );

endinterface

// File: rtl/sa_pe.sv
// Systolic PE: saturating unsigned multiply-accumulate, forwards a east and b south.
// One-cycle forwarding latency; holds everything while en is low.
module sa_pe
  import sa_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              res,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      sum;

  assign prod = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
  // One spare bit above the accumulator exposes the saturation condition.
  assign sum  = {1'b0, acc} + {{(ACC_W + 1 - 2*DATA_W){1'b0}}, prod};

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      if (sum[ACC_W]) begin
        acc <= '1;
        ovf <= 1'b1;
      end else begin
        acc <= sum[ACC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/systolic_matmul.sv
// N x N output-stationary systolic multiplier with input skew and run-control FSM.
// Result valid K+2N-2 advances after start; input stalls and out_ready backpressure hold all state.
module systolic_matmul
  import sa_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int K_W    = DEF_K_W
) (
  input  logic             clk,
  input  logic             res,
  systolic_matmul_if.slave io
);

  localparam int DC_W = $clog2(2*N);

  sa_state_t       state, nxt;
  logic [K_W-1:0]  k_reg;
  logic [K_W-1:0]  beat;
  logic [DC_W-1:0] dcnt;
  logic            go, clr, adv, feed;
  logic            last_beat, last_drain;

  logic [DATA_W-1:0] a_feed [N];
  logic [DATA_W-1:0] b_feed [N];
  logic [DATA_W-1:0] a_edge [N];
  logic [DATA_W-1:0] b_edge [N];
  logic [DATA_W-1:0] a_h    [N][N+1];
  logic [DATA_W-1:0] b_v    [N+1][N];
  logic [ACC_W-1:0]  acc_v  [N][N];
  logic [N*N-1:0]    ovf_v;

  // A zero-length run is treated as no request at all.
  assign go         = (state == IDLE) && io.start && (io.k_len != '0);
  assign clr        = go && !io.acc_mode;
  assign last_beat  = (beat == k_reg - K_W'(1));
  assign last_drain = (dcnt == DC_W'(2*N - 3));

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (go) nxt = LOAD;
      LOAD:    if (io.in_valid && last_beat) nxt = DRAIN;
      DRAIN:   if (last_drain) nxt = DONE;
      DONE:    if (io.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    io.busy      = 1'b0;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    adv          = 1'b0;
    feed         = 1'b0;
    case (state)
      LOAD: begin
        io.busy     = 1'b1;
        io.in_ready = 1'b1;
        feed        = 1'b1;
        adv         = io.in_valid;
      end
      DRAIN: begin
        io.busy = 1'b1;
        adv     = 1'b1;
      end
      DONE: begin
        io.busy      = 1'b1;
        io.out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      k_reg <= '0;
      beat  <= '0;
      dcnt  <= '0;
    end else if (go) begin
      k_reg <= io.k_len;
      beat  <= '0;
      dcnt  <= '0;
    end else begin
      if (state == LOAD && io.in_valid) beat <= beat + K_W'(1);
      if (state == DRAIN)               dcnt <= dcnt + DC_W'(1);
    end
  end

  // Row i / column i are delayed by i stages so beat k meets PE(i,j) at advance k+i+j.
  for (genvar i = 0; i < N; i++) begin : g_skew_row
    assign a_feed[i] = feed ? io.a_col[i*DATA_W +: DATA_W] : '0;
    assign b_feed[i] = feed ? io.b_row[i*DATA_W +: DATA_W] : '0;

    if (i == 0) begin : g_direct
      assign a_edge[i] = a_feed[i];
      assign b_edge[i] = b_feed[i];
    end else begin : g_delay
      logic [DATA_W-1:0] a_sr [i];
      logic [DATA_W-1:0] b_sr [i];

      always_ff @(posedge clk or posedge res) begin
        if (res) begin
          for (int s = 0; s < i; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else if (adv) begin
          a_sr[0] <= a_feed[i];
          b_sr[0] <= b_feed[i];
          for (int s = 1; s < i; s++) begin
            a_sr[s] <= a_sr[s-1];
            b_sr[s] <= b_sr[s-1];
          end
        end
      end

      assign a_edge[i] = a_sr[i-1];
      assign b_edge[i] = b_sr[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_edge
    assign a_h[i][0] = a_edge[i];
    assign b_v[0][i] = b_edge[i];
  end

  for (genvar i = 0; i < N; i++) begin : g_pe_row
    for (genvar j = 0; j < N; j++) begin : g_pe_col
      sa_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk   (clk),
        .res   (res),
        .en    (adv),
        .clr   (clr),
        .a_in  (a_h[i][j]),
        .b_in  (b_v[i][j]),
        .a_out (a_h[i][j+1]),
        .b_out (b_v[i+1][j]),
        .acc   (acc_v[i][j]),
        .ovf   (ovf_v[i*N + j])
      );

      assign io.out_c[c_lsb(i, j, N, ACC_W) +: ACC_W] = acc_v[i][j];
    end
  end

  assign io.overflow = |ovf_v;

endmodule

// File: tb/tb_systolic_matmul.sv
// Directed bench for systolic_matmul: identity, accumulate, stalls, backpressure,
// ignored starts, saturation and asynchronous reset in the middle of a run.
module tb_systolic_matmul;
  import sa_pkg::*;

  localparam int N      = 4;
  localparam int DATA_W = 4;
  localparam int ACC_W  = 10;
  localparam int K_W    = 8;
  localparam int CW     = N*N*ACC_W;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat;

  systolic_matmul_if #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_W(K_W)) io ();

  systolic_matmul #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_W(K_W)) dut (
    .clk (clk),
    .res (res),
    .io  (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind 0: B of the identity run (B[3][3]=16 wraps to 0 in 4 bits), 1: twice that,
  // 2: K=4 all-15 products (900), 3: saturated (1023).
  function automatic logic [CW-1:0] exp_c(input int kind);
    logic [CW-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        case (kind)
          0:       v = (4*i + j + 1) % 16;
          1:       v = 2 * ((4*i + j + 1) % 16);
          2:       v = 900;
          default: v = 1023;
        endcase
        r[(i*N + j)*ACC_W +: ACC_W] = ACC_W'(v);
      end
    end
    return r;
  endfunction

  task automatic drive_beat(input int pt, input int k);
    for (int i = 0; i < N; i++) begin
      io.a_col[i*DATA_W +: DATA_W] = (pt == 0) ? ((i == k) ? 4'd1 : 4'd0) : 4'd15;
      io.b_row[i*DATA_W +: DATA_W] = (pt == 0) ? DATA_W'(4*k + i + 1) : 4'd15;
    end
  endtask

  // Starts a run and streams k beats; returns once out_valid is seen or the bound expires.
  task automatic run(input int k, input logic amode, input int pt, input bit stall,
                     input bit poke, output int lat_o);
    int beat = 0;
    int cyc  = 0;
    bit v;
    io.start    = 1'b1;
    io.k_len    = K_W'(k);
    io.acc_mode = amode;
    @(posedge clk); #1;
    io.start = 1'b0;
    lat_o    = 0;
    while (beat < k && cyc < 100) begin
      v = !stall || (cyc % 3 == 0);
      io.in_valid = v;
      if (v) drive_beat(pt, beat);
      else begin
        io.a_col = '1;
        io.b_row = '1;
      end
      io.start    = poke && (cyc == 1);
      io.k_len    = (poke && cyc == 1) ? K_W'(2) : K_W'(k);
      io.acc_mode = (poke && cyc == 1) ? 1'b0 : amode;
      @(posedge clk); #1;
      lat_o++;
      cyc++;
      if (v) beat++;
    end
    io.start    = 1'b0;
    io.in_valid = 1'b0;
    io.a_col    = '0;
    io.b_row    = '0;
    while (!io.out_valid && lat_o < 200) begin
      @(posedge clk); #1;
      lat_o++;
    end
  endtask

  task automatic accept(input string tag);
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    chk(tag, io.out_valid, 1'b0);
  endtask

  initial begin
    io.start     = 1'b0;
    io.k_len     = '0;
    io.acc_mode  = 1'b0;
    io.in_valid  = 1'b0;
    io.a_col     = '0;
    io.b_row     = '0;
    io.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  io.busy,      1'b0);
    chk("rst_ready", io.in_ready,  1'b0);
    chk("rst_valid", io.out_valid, 1'b0);
    chk("rst_c",     io.out_c,     '0);
    chk("rst_ovf",   io.overflow,  1'b0);
    res = 1'b0;
    @(posedge clk); #1;

    run(4, 1'b0, 0, 1'b0, 1'b0, lat);
    chk("id_lat",   lat, 10);
    chk("id_valid", io.out_valid, 1'b1);
    chk("id_c",     io.out_c, exp_c(0));
    chk("id_c23",   io.out_c[(2*N + 3)*ACC_W +: ACC_W], 12);
    chk("id_ovf",   io.overflow, 1'b0);
    accept("id_accept");

    io.start = 1'b1;
    io.k_len = '0;
    @(posedge clk); #1;
    io.start = 1'b0;
    chk("k0_busy", io.busy, 1'b0);
    chk("k0_c",    io.out_c, exp_c(0));

    run(4, 1'b1, 0, 1'b0, 1'b0, lat);
    chk("acc_double", io.out_c, exp_c(1));
    accept("acc_accept");
    run(4, 1'b0, 0, 1'b0, 1'b0, lat);
    chk("acc_single", io.out_c, exp_c(0));
    accept("single_accept");

    run(4, 1'b0, 0, 1'b1, 1'b0, lat);
    chk("stall_lat", lat, 16);
    chk("stall_c",   io.out_c, exp_c(0));
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      chk("hold_valid", io.out_valid, 1'b1);
      chk("hold_c",     io.out_c, exp_c(0));
    end
    accept("hold_accept");

    run(4, 1'b1, 0, 1'b0, 1'b1, lat);
    chk("poke_lat", lat, 10);
    chk("poke_c",   io.out_c, exp_c(1));
    accept("poke_accept");

    run(4, 1'b0, 1, 1'b0, 1'b0, lat);
    chk("sat4_c",   io.out_c, exp_c(2));
    chk("sat4_ovf", io.overflow, 1'b0);
    accept("sat4_accept");
    run(5, 1'b0, 1, 1'b0, 1'b0, lat);
    chk("sat5_c",   io.out_c, exp_c(3));
    chk("sat5_ovf", io.overflow, 1'b1);
    accept("sat5_accept");

    io.start    = 1'b1;
    io.k_len    = K_W'(4);
    io.acc_mode = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      io.in_valid = 1'b1;
      drive_beat(0, k);
      @(posedge clk); #1;
    end
    io.in_valid = 1'b0;
    io.a_col    = '0;
    io.b_row    = '0;
    @(posedge clk); #1;
    chk("drain_busy",  io.busy,     1'b1);
    chk("drain_ready", io.in_ready, 1'b0);
    chk("drain_ovf",   io.overflow, 1'b1);
    res = 1'b1;
    #1;
    chk("ares_busy",  io.busy,      1'b0);
    chk("ares_valid", io.out_valid, 1'b0);
    chk("ares_c",     io.out_c,     '0);
    chk("ares_ovf",   io.overflow,  1'b0);
    #2;
    res = 1'b0;
    @(posedge clk); #1;

    run(4, 1'b0, 0, 1'b0, 1'b0, lat);
    chk("post_lat", lat, 10);
    chk("post_c",   io.out_c, exp_c(0));
    chk("post_ovf", io.overflow, 1'b0);
    accept("post_accept");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/systolic_matmul.md
Name: systolic_matmul

Overview:
Parametrised N x N output-stationary systolic matrix multiplier. It computes C = A x B over a run-time inner dimension k_len. The block contains its own input-skew registers and a control FSM, so the producer streams plain A columns and B rows through a valid/ready handshake. Results are held packed on out_c until the consumer accepts them. Optionally, results accumulate across runs.

Parameters:
N, 4, array dimension (N x N PEs, N rows of A, N columns of B)
DATA_W, 4, unsigned operand width
ACC_W, 10, unsigned accumulator width per PE (must be >= 2*DATA_W)
K_W, 8, width of k_len

Ports:
clk  in  1  clock; all state rising-edge
res  in  1  reset, asynchronous, active-high
start  in  1  begin a run (sampled in IDLE only)
k_len  in  K_W  inner dimension K for the run, latched on start
acc_mode  in  1  latched on start; 0 = clear accumulators, 1 = accumulate onto previous C
busy  out  1  high in LOAD, DRAIN, DONE
in_valid  in  1  producer has a beat
in_ready  out  1  block accepts a beat (high only in LOAD)
a_col  in  N*DATA_W  slice i = A[i][k] for the current beat k
b_row  in  N*DATA_W  slice j = B[k][j] for the current beat k
out_valid  out  1  out_c holds a finished result
out_ready  in  1  consumer accepts out_c
out_c  out  N*N*ACC_W  slice (i*N+j) = C[i][j]
overflow  out  1  sticky: some accumulator saturated since the last clearing start

Behaviour:
- Reset (async, any state, mid-run included): FSM returns to IDLE. All accumulators, skew and PE pipeline registers, the beat counter and the overflow flag clear to 0. Outputs: busy=0, in_ready=0, out_valid=0, out_c=0, overflow=0.
- FSM states:
  - IDLE:
    - start=1 with k_len!=0 -> LOAD. On the same edge: latch k_len and acc_mode; if acc_mode=0, clear all accumulators and overflow.
    - start=1 with k_len=0 -> ignored; stay in IDLE, nothing changes.
  - LOAD: in_ready=1. Each edge with in_valid=1 is one beat: the array advances one step and the beat counter increments. After beat k_len-1 -> DRAIN.
  - DRAIN: in_ready=0. Zeros are injected at both edges. The array advances every cycle for exactly 2N-2 cycles, then -> DONE.
  - DONE: out_valid=1 and out_c is stable. On out_valid & out_ready -> IDLE with out_valid=0. out_c keeps its last value in IDLE.
- start is ignored outside IDLE.
- Advance enable = (LOAD & in_valid) | DRAIN. When advance=0, every skew, PE and accumulator register holds (stall).
- Skew: row i of A passes through i register stages before PE(i,0); column j of B passes through j stages before PE(0,j). Row 0 and column 0 are unregistered from the ports.
- PE(i,j), on each advance edge:
  - acc <= sat(acc + a_in*b_in)
  - a_out <= a_in (to PE(i,j+1)); b_out <= b_in (to PE(i+1,j))
  - Product is 2*DATA_W bits, unsigned.
  - Sum is computed at ACC_W+1 bits; if it exceeds 2^ACC_W-1, acc becomes 2^ACC_W-1 and overflow sets.
- PE(i,j) consumes beat k at advance index k+i+j. Total advances = K+2N-2.
- Latency with in_valid held high: out_valid rises K+2N-2 edges after the edge that sampled start (K=4, N=4 -> 10).
- out_c is driven directly from the accumulators; it is meaningful while out_valid=1.

Decomposition:
- Shared package sa_pkg:
  - FSM state encoding constants IDLE/LOAD/DRAIN/DONE
  - default N/DATA_W/ACC_W/K_W
  - slice-index helper for out_c packing
- One sub-module, sa_pe: the processing element, with ports for enable, synchronous clear, saturation and an overflow output.
- Top level contains the generate loop of PEs, the skew registers, the beat/drain counters and the FSM.

Test Plan:
- Identity: N=4, K=4, A=I, B[k][j]=4k+j+1, in_valid held high -> out_c equals B (C[2][3]=12). out_valid rises exactly 10 edges after the start edge. overflow=0.
- Saturation: all operands 15, ACC_W=10.
  - K=4 -> every C=900, overflow=0.
  - K=5 -> every C=1023, overflow=1.
- Stalls and backpressure:
  - Repeat the identity run with in_valid toggling 1,0,0,1,... -> identical out_c, and out_valid delayed by the number of idle cycles.
  - Hold out_ready=0 for 20 cycles -> out_valid stays 1 and out_c stays stable throughout.
- Accumulate: run the identity run with acc_mode=0, then again with acc_mode=1 -> C[i][j]=2*(4i+j+1). A third run with acc_mode=0 -> values return to single.
- Ignored starts:
  - start with k_len=0 -> block stays in IDLE, busy=0, out_c unchanged.
  - start asserted during LOAD -> no effect on the run.
- Reset mid-run: assert res during DRAIN -> asynchronously busy=0, out_c=0, overflow=0. A following full run produces the correct result.
